// File: rtl/biu_bus_arbiter.sv
// Three-way AHB master-port arbiter for the BIU: TLB, L1 and external master.
// Ownership changes only at a quiet bus boundary, always via one parked IDLE cycle.
module biu_bus_arbiter #(
  parameter int STARVE_LIMIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tlb_req,
  output logic       tlb_ack,
  input  logic       l1_req,
  output logic       l1_ack,
  input  logic       ext_req,
  output logic       ext_ack,
  input  logic [1:0] htrans,
  input  logic       hready,
  input  logic       hmastlock,
  output logic [1:0] owner,
  output logic       bus_busy,
  output logic [1:0] state_o,
  output logic [7:0] starve_cnt_o
);

  // Handshake: each req is a level; its ack is high for exactly as long as that
  // requester owns the bus. Once granted, the owner keeps the bus while req stays
  // high; after req drops, the ack falls one edge after the bus is quiet
  // (htrans IDLE, hready high, no lock). Acks are mutually exclusive.

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GNT_TLB = 2'b01,
    GNT_L1  = 2'b10,
    GNT_EXT = 2'b11
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] starve_q, starve_d;
  logic       owner_req;
  logic       release_ok;
  logic       boost;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      starve_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    owner_req = 1'b0;
    case (state_q)
      GNT_TLB: owner_req = tlb_req;
      GNT_L1:  owner_req = l1_req;
      GNT_EXT: owner_req = ext_req;
      default: owner_req = 1'b0;
    endcase
  end

  assign release_ok = !owner_req && (htrans == 2'b00) && hready && !hmastlock;
  assign boost      = l1_req && (starve_q == LIMIT);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (boost)        state_d = GNT_L1;
        else if (ext_req) state_d = GNT_EXT;
        else if (tlb_req) state_d = GNT_TLB;
        else if (l1_req)  state_d = GNT_L1;
      end
      default: begin
        if (release_ok) state_d = IDLE;
      end
    endcase
  end

  // Counts cycles L1 waits; it sits at LIMIT until L1 is finally granted.
  always_comb begin
    starve_d = starve_q;
    if (!l1_req || l1_ack)   starve_d = 8'd0;
    else if (starve_q < LIMIT) starve_d = starve_q + 8'd1;
  end

  assign owner        = state_q;
  assign tlb_ack      = (state_q == GNT_TLB);
  assign l1_ack       = (state_q == GNT_L1);
  assign ext_ack      = (state_q == GNT_EXT);
  assign bus_busy     = (state_q != IDLE);
  assign state_o      = state_q;
  assign starve_cnt_o = starve_q;

endmodule

// File: tb/tb_biu_bus_arbiter.sv
// Directed bench for biu_bus_arbiter: a driver queues the expected post-edge
// owner / starve count per cycle, a monitor pops and compares on the falling edge.
module tb_biu_bus_arbiter;

  localparam int W = 11;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tlb_req = 1'b0, l1_req = 1'b0, ext_req = 1'b0;
  logic [1:0] htrans = 2'b00;
  logic       hready = 1'b1, hmastlock = 1'b0;
  logic       tlb_ack, l1_ack, ext_ack, bus_busy;
  logic [1:0] owner, state_o;
  logic [7:0] starve_cnt_o;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  biu_bus_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .tlb_req(tlb_req), .tlb_ack(tlb_ack),
    .l1_req(l1_req), .l1_ack(l1_ack),
    .ext_req(ext_req), .ext_ack(ext_ack),
    .htrans(htrans), .hready(hready), .hmastlock(hmastlock),
    .owner(owner), .bus_busy(bus_busy),
    .state_o(state_o), .starve_cnt_o(starve_cnt_o)
  );

  // One clock: apply inputs, then queue the state expected after the edge.
  // es < 0 means the starve count is not checked on this cycle.
  task automatic step(input logic r, input logic t, input logic l, input logic e,
                      input logic [1:0] ht, input logic hr, input logic hl,
                      input logic [1:0] eo, input int es);
    logic [7:0] s;
    logic       chk;
    rst = r; tlb_req = t; l1_req = l; ext_req = e;
    htrans = ht; hready = hr; hmastlock = hl;
    s   = es[7:0];
    chk = (es >= 0);
    @(posedge clk);
    exp_q.push_back({chk, s, eo});
    @(negedge clk);
  endtask

  initial begin : monitor
    int         n;
    logic [W-1:0] e;
    logic [5:0] exp_out, act_out;
    n = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n++;
        exp_out = {e[1:0], e[1:0] == 2'b01, e[1:0] == 2'b10, e[1:0] == 2'b11, e[1:0] != 2'b00};
        act_out = {owner, tlb_ack, l1_ack, ext_ack, bus_busy};
        checks++;
        if (act_out !== exp_out) begin
          errors++;
          $display("FAIL grant cycle %0d: owner/tlb/l1/ext/busy got %b expected %b", n, act_out, exp_out);
        end
        if (e[10]) begin
          checks++;
          if (starve_cnt_o !== e[9:2]) begin
            errors++;
            $display("FAIL starve_cnt cycle %0d: got %0d expected %0d", n, starve_cnt_o, e[9:2]);
          end
        end
      end
    end
  end

  initial begin : driver
    // Reset
    step(1, 0,0,0, 2'b00,1,0, 2'b00, 0);
    step(0, 0,0,0, 2'b00,1,0, 2'b00, 0);

    // Single TLB request, release on a quiet bus
    step(0, 1,0,0, 2'b00,1,0, 2'b01, 0);
    step(0, 1,0,0, 2'b10,1,0, 2'b01, 0);
    step(0, 1,0,0, 2'b10,1,0, 2'b01, 0);
    step(0, 1,0,0, 2'b10,1,0, 2'b01, 0);
    step(0, 0,0,0, 2'b00,1,0, 2'b00, 0);
    step(0, 0,0,0, 2'b00,1,0, 2'b00, 0);

    // Reset mid-grant drops L1 despite active transfer and lock
    step(0, 0,1,0, 2'b00,1,0, 2'b10, 1);
    step(0, 0,1,0, 2'b10,1,0, 2'b10, 0);
    step(1, 0,1,0, 2'b10,1,1, 2'b00, 0);
    step(0, 0,0,0, 2'b00,1,0, 2'b00, 0);

    // Priority: EXT, then TLB after a park cycle, then L1
    step(0, 1,1,1, 2'b00,1,0, 2'b11, 1);
    step(0, 1,1,1, 2'b10,1,0, 2'b11, 2);
    step(0, 1,1,0, 2'b00,1,0, 2'b00, 3);
    step(0, 1,1,0, 2'b00,1,0, 2'b01, 4);
    step(0, 1,1,0, 2'b10,1,0, 2'b01, 4);
    step(0, 0,1,0, 2'b00,1,0, 2'b00, 4);
    step(0, 0,1,0, 2'b00,1,0, 2'b10, 4);
    step(0, 0,0,0, 2'b00,1,0, 2'b00, 0);
    step(0, 0,0,0, 2'b00,1,0, 2'b00, 0);

    // Safe handover: active transfer with wait states, then hready low alone
    step(0, 0,1,0, 2'b00,1,0, 2'b10, 1);
    step(0, 0,1,0, 2'b10,1,0, 2'b10, 0);
    for (int i = 0; i < 3; i++) step(0, 0,0,0, 2'b10,0,0, 2'b10, 0);
    step(0, 0,0,0, 2'b00,0,0, 2'b10, 0);
    step(0, 0,0,0, 2'b00,1,0, 2'b00, 0);
    step(0, 0,0,0, 2'b00,1,0, 2'b00, 0);

    // Locked sequence holds the grant
    step(0, 0,1,0, 2'b00,1,0, 2'b10, 1);
    step(0, 0,1,0, 2'b10,1,1, 2'b10, 0);
    step(0, 0,0,0, 2'b00,1,1, 2'b10, 0);
    step(0, 0,0,0, 2'b00,1,1, 2'b10, 0);
    step(0, 0,0,0, 2'b00,1,0, 2'b00, 0);

    // Starvation: L1 waits through a 6-cycle EXT grant, saturates, no preemption
    step(0, 0,1,1, 2'b00,1,0, 2'b11, 1);
    step(0, 0,1,1, 2'b10,1,0, 2'b11, 2);
    step(0, 0,1,1, 2'b10,1,0, 2'b11, 3);
    step(0, 0,1,1, 2'b10,1,0, 2'b11, 4);
    step(0, 0,1,1, 2'b10,1,0, 2'b11, 4);
    step(0, 0,1,1, 2'b10,1,0, 2'b11, 4);
    step(0, 1,1,0, 2'b00,1,0, 2'b00, 4);
    step(0, 1,1,1, 2'b00,1,0, 2'b10, 4);
    step(0, 1,1,1, 2'b10,1,0, 2'b10, 0);
    step(0, 1,0,1, 2'b00,1,0, 2'b00, 0);
    step(0, 1,0,1, 2'b00,1,0, 2'b11, 0);
    step(0, 1,0,0, 2'b00,1,0, 2'b00, 0);
    step(0, 1,0,0, 2'b00,1,0, 2'b01, 0);
    step(0, 0,0,0, 2'b00,1,0, 2'b00, 0);

    // Pulsed TLB request during an EXT grant is never seen
    step(0, 0,0,1, 2'b00,1,0, 2'b11, 0);
    step(0, 1,0,1, 2'b10,1,0, 2'b11, 0);
    step(0, 0,0,1, 2'b10,1,0, 2'b11, 0);
    step(0, 0,0,0, 2'b00,1,0, 2'b00, 0);
    step(0, 0,0,0, 2'b00,1,0, 2'b00, 0);
    step(0, 0,0,0, 2'b00,1,0, 2'b00, 0);

    for (int i = 0; i < 10; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/biu_bus_arbiter.md
# biu_bus_arbiter

Arbiter that shares the single AHB master port of the BIU among three requesters: the TLB bus unit (page walks and PTE write-back), the L1 cache bus unit (line fills and write-through), and an external bus master. It runs a registered req/ack handshake with each requester. It hands the bus over only at a safe AHB boundary. It drives an owner select that the downstream AHB mux uses to route address, control and data.

## Interface
Parameters:
- STARVE_LIMIT, 16: consecutive cycles a pending L1 request may go ungranted before it is boosted to top priority; legal range 1..255.

Ports:
- Clocking and reset: one clock; reset is synchronous and active-high.
  - clk  in  1  clock, all state updates on the rising edge.
  - rst  in  1  synchronous, active-high reset.
- Requester handshakes:
  - tlb_req  in  1  TLB bus unit requests the bus.
  - tlb_ack  out  1  bus granted to the TLB bus unit.
  - l1_req  in  1  L1 cache bus unit requests the bus.
  - l1_ack  out  1  bus granted to the L1 cache bus unit.
  - ext_req  in  1  external master requests the bus.
  - ext_ack  out  1  bus granted to the external master.
- Shared AHB bus monitor (signals as seen on the shared bus):
  - htrans  in  2  current transfer type of the muxed bus; 00 = IDLE.
  - hready  in  1  slave ready on the shared bus.
  - hmastlock  in  1  locked sequence in progress on the muxed bus.
- Outputs to the AHB mux:
  - owner  out  2  mux select: 00 none/park, 01 TLB, 10 L1, 11 EXT.
  - bus_busy  out  1  high whenever owner != 00.

## Operation
- State machine states:
  - IDLE: owner = 00, all acks 0.
  - GNT_TLB, GNT_L1, GNT_EXT: exactly one ack high; owner = 01, 10 or 11 respectively.
- IDLE → GNT_x at the next edge. The winner is taken among the requesters whose req is sampled high in IDLE:
  - Boosted L1 (starve_cnt == STARVE_LIMIT and l1_req) > EXT > TLB > L1.
  - No req high: remain in IDLE.
- GNT_x → IDLE when the release condition is met in the same cycle. Release condition: owner's req == 0 and htrans == 00 and hready == 1 and hmastlock == 0.
  - If the owner drops req while a transfer is still active, hready is low, or hmastlock is high: hold the grant until the condition is met.
  - The owner keeps the grant as long as its req stays high. There is no preemption, including by a boosted L1.
- Every change of ownership passes through at least one IDLE cycle (bus park). owner is never switched directly from one requester to another.
- Starvation counter starve_cnt:
  - Width 8 bits.
  - Increments each cycle l1_req == 1 and l1_ack == 0; saturates at STARVE_LIMIT.
  - Clears to 0 when l1_ack is asserted or l1_req == 0.
- Requests are level-sensitive; only the value in the arbitration cycle matters. A req that pulses high and drops before an IDLE cycle samples it is never granted.
- Acks and owner are registered state outputs and are mutually exclusive at all times.

## Timing
- Reset: IDLE, tlb_ack = l1_ack = ext_ack = 0, owner = 00, bus_busy = 0, starve_cnt = 0. Reset has priority over every transition, including mid-grant; the grant is dropped at the reset edge regardless of htrans or hmastlock.
- Grant latency from IDLE: req high at edge N → ack high after edge N+1 (one cycle).
- Release latency: release condition true in cycle N → ack low and owner = 00 after edge N+1. The earliest new grant is after edge N+2.
- Back-to-back requests by the same requester: it re-arbitrates normally after the IDLE cycle and gets no affinity.
- Simultaneous events:
  - Owner release and another req in the same cycle: IDLE first, then that requester is granted one cycle later.
  - All three reqs high in IDLE with no boost: EXT wins.
- Starvation bound: L1 is granted at the first IDLE cycle after starve_cnt reaches STARVE_LIMIT.

## Test plan
- Reset mid-grant: l1_req = 1 granted, htrans = 10, then rst = 1 for one cycle → next cycle all acks 0, owner = 00, starve_cnt = 0.
- Single request: tlb_req rises at cycle 0 → tlb_ack = 1 and owner = 01 from cycle 1. Drop tlb_req at cycle 5 with htrans = 00, hready = 1 → tlb_ack = 0 and owner = 00 at cycle 6.
- Priority: ext_req, tlb_req and l1_req all high in IDLE → ext_ack only. After EXT releases, one IDLE cycle, then tlb_ack; L1 is granted only after TLB releases.
- Safe handover: owner L1 drops l1_req while htrans = 10 and hready = 0 for 3 cycles → l1_ack stays 1. Once htrans = 00 and hready = 1 → release next edge. Repeat with hmastlock = 1 → hold until hmastlock = 0.
- Starvation, STARVE_LIMIT = 4: l1_req held high while EXT and TLB alternate with 6-cycle grants → starve_cnt saturates at 4, and L1 is granted at the next IDLE even with ext_req = 1.
- Pulse request: tlb_req high for one cycle while EXT owns the bus, low before EXT releases → tlb_ack never asserts and owner stays 00 after release.
